// File: rtl/melody_pkg.sv
// melody_pkg: constants and types shared by the melody sequencer and the
// square-wave tone generator.
//   - note codes stored in the upper nibble of a song table entry
//   - half-period terminal counts (prescaled generator ticks) for each note
//   - song table entry layout {note[7:4], dur[3:0]} and field helpers
//   - sequencer state encoding
package melody_pkg;

  // Note codes. Codes 9..15 are not musical notes and play as rests.
  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DUO  = 4'd1;
  localparam logic [3:0] NOTE_LAI  = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SUO  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_XI   = 4'd7;
  localparam logic [3:0] NOTE_DUO1 = 4'd8;

  // Half-period terminal counts, also used by the tone generator.
  localparam int unsigned HP_W = 13;
  localparam logic [HP_W-1:0] HP_DUO  = 13'd3822;
  localparam logic [HP_W-1:0] HP_LAI  = 13'd3405;
  localparam logic [HP_W-1:0] HP_MI   = 13'd3034;
  localparam logic [HP_W-1:0] HP_FA   = 13'd2865;
  localparam logic [HP_W-1:0] HP_SUO  = 13'd2551;
  localparam logic [HP_W-1:0] HP_LA   = 13'd2273;
  localparam logic [HP_W-1:0] HP_XI   = 13'd2024;
  localparam logic [HP_W-1:0] HP_DUO1 = 13'd1911;

  // Song table entry layout.
  localparam int unsigned ENTRY_W  = 8;
  localparam int unsigned NOTE_MSB = 7;
  localparam int unsigned NOTE_LSB = 4;
  localparam int unsigned DUR_MSB  = 3;
  localparam int unsigned DUR_LSB  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StPlay,
    StGap,
    StEnd
  } state_e;

  function automatic logic [3:0] entry_note(input logic [ENTRY_W-1:0] entry);
    return entry[NOTE_MSB:NOTE_LSB];
  endfunction

  // Duration in units; 0 marks the end of the song.
  function automatic logic [3:0] entry_dur(input logic [ENTRY_W-1:0] entry);
    return entry[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/note_lut.sv
// note_lut: combinational note code -> half-period lookup.
// Ports:
//   code        in   4   note code from a song table entry
//   half_period out  13  generator terminal count (0 for rests)
//   valid       out  1   1 for audible notes (codes 1..8), 0 for rests
module note_lut
  import melody_pkg::*;
(
  input  logic [3:0]      code,
  output logic [HP_W-1:0] half_period,
  output logic            valid
);

  always_comb begin
    half_period = '0;
    valid       = 1'b1;
    unique case (code)
      NOTE_DUO:  half_period = HP_DUO;
      NOTE_LAI:  half_period = HP_LAI;
      NOTE_MI:   half_period = HP_MI;
      NOTE_FA:   half_period = HP_FA;
      NOTE_SUO:  half_period = HP_SUO;
      NOTE_LA:   half_period = HP_LA;
      NOTE_XI:   half_period = HP_XI;
      NOTE_DUO1: half_period = HP_DUO1;
      default:   valid = 1'b0;  // NOTE_REST and unused codes 9..15
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a programmable song table into the tone generator.
// Each entry {note, dur} sounds for dur*UNIT_CYCLES cycles and is followed by
// GAP_CYCLES of silence so repeated notes stay distinct.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start        pulse, begins playback at entry 0 when idle
//   stop         aborts playback (highest priority)
//   loop         sampled at end of song; 1 restarts at entry 0
//   wr_en/wr_addr/wr_data  table write port, honoured only while idle
//   half_period  tone generator terminal count
//   tone_en      1 = generator toggles, 0 = silent
//   note_idx     index of the entry being played
//   busy         high whenever not idle
//   done         one-cycle pulse at the end of a non-looping song
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned SONG_LEN    = 16,
  parameter int unsigned UNIT_CYCLES = 1500000,
  parameter int unsigned GAP_CYCLES  = 120000,
  parameter int unsigned AW          = $clog2(SONG_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [HP_W-1:0]    half_period,
  output logic               tone_en,
  output logic [AW-1:0]      note_idx,
  output logic               busy,
  output logic               done
);

  // One down-counter serves both PLAY and GAP, so size it for the longer one.
  localparam longint unsigned PlayMax = 64'(15) * 64'(UNIT_CYCLES);
  localparam longint unsigned CntMax  = (PlayMax > 64'(GAP_CYCLES)) ? PlayMax : 64'(GAP_CYCLES);
  localparam int unsigned     CntW    = $clog2(CntMax + 64'(1));
  localparam logic [AW-1:0]   LastAddr = AW'(SONG_LEN - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [HP_W-1:0]     hp_q, hp_d;
  logic                tone_q, tone_d;
  logic [AW-1:0]       idx_q, idx_d;

  logic [ENTRY_W-1:0]  mem [SONG_LEN];
  logic [ENTRY_W-1:0]  fetch_entry;
  logic [3:0]          fetch_dur;
  logic [HP_W-1:0]     lut_hp;
  logic                lut_valid;

  // Table storage has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == StIdle)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The entry addressed during FETCH is decoded combinationally and captured
  // into the PLAY registers on the FETCH exit edge, giving the one-cycle
  // registered read. A write in the start cycle is therefore already visible.
  assign fetch_entry = mem[addr_q];
  assign fetch_dur   = entry_dur(fetch_entry);

  note_lut u_note_lut (
    .code        (entry_note(fetch_entry)),
    .half_period (lut_hp),
    .valid       (lut_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      hp_q    <= '0;
      tone_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      tone_q  <= tone_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    tone_d  = tone_q;
    idx_d   = idx_q;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StFetch;
          addr_d  = '0;
        end
      end

      StFetch: begin
        if (fetch_dur == 4'd0) begin
          state_d = StEnd;
        end else begin
          state_d = StPlay;
          cnt_d   = CntW'(fetch_dur) * CntW'(UNIT_CYCLES) - CntW'(1);
          hp_d    = lut_hp;
          tone_d  = lut_valid;
          idx_d   = addr_q;
        end
      end

      StPlay: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = CntW'(GAP_CYCLES - 1);
          tone_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StGap: begin
        if (cnt_q == '0) begin
          // Running off the last entry ends the song like a marker would.
          if (addr_q == LastAddr) begin
            state_d = StEnd;
          end else begin
            state_d = StFetch;
            addr_d  = addr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StEnd: begin
        if (loop) begin
          state_d = StFetch;
          addr_d  = '0;
        end else begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    // Abort overrides every transition above, including the done pulse.
    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
      tone_d  = 1'b0;
      done    = 1'b0;
    end
  end

  assign half_period = hp_q;
  assign tone_en     = tone_q;
  assign note_idx    = idx_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer with SONG_LEN=4, UNIT_CYCLES=4, GAP_CYCLES=2.
// A reference model expands the song table into the expected per-cycle output
// trace; a vector table checks note decode; hand sequences cover aborts,
// resets and write/start interactions.
module tb_melody_sequencer;

  localparam int unsigned LEN = 4;
  localparam int unsigned U   = 4;
  localparam int unsigned G   = 2;
  localparam int unsigned AW  = 2;

  logic          clk = 1'b0;
  logic          rst, start, stop, loop, wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [12:0]   half_period;
  logic          tone_en;
  logic [AW-1:0] note_idx;
  logic          busy, done;

  always #5 clk = ~clk;

  melody_sequencer #(
    .SONG_LEN    (LEN),
    .UNIT_CYCLES (U),
    .GAP_CYCLES  (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .half_period (half_period),
    .tone_en     (tone_en),
    .note_idx    (note_idx),
    .busy        (busy),
    .done        (done)
  );

  // full=0: only busy/tone/done are defined for that cycle.
  typedef struct packed {
    logic          full;
    logic          busy;
    logic          tone;
    logic [12:0]   hp;
    logic [AW-1:0] idx;
    logic          done;
  } obs_t;

  typedef struct packed {
    logic [7:0]  data;
    logic [12:0] hp;
    logic        tone;
  } vec_t;

  obs_t        exp_q[$];
  logic [7:0]  song [LEN];
  int unsigned hp_ref [16];
  vec_t        vecs [16];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk(bit full, bit b, bit t, int hp, int idx, bit d);
    obs_t o;
    o.full = full;
    o.busy = b;
    o.tone = t;
    o.hp   = 13'(hp);
    o.idx  = AW'(idx);
    o.done = d;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t e);
    logic ok;
    n_checks++;
    ok = (busy === e.busy) && (tone_en === e.tone) && (done === e.done);
    if (e.full) ok = ok && (half_period === e.hp) && (note_idx === e.idx);
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got busy=%b tone=%b done=%b hp=%0d idx=%0d, want busy=%b tone=%b done=%b hp=%0d idx=%0d (hp/idx checked=%b)",
               name, busy, tone_en, done, half_period, note_idx,
               e.busy, e.tone, e.done, e.hp, e.idx, e.full);
    end
  endtask

  task automatic write_entry(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr_en   = 1'b0;
    song[a] = d;
  endtask

  // Expected trace starting with the cycle after start is sampled.
  task automatic build_trace(input bit lp, input int max_n);
    int i, note, dur, hp;
    exp_q.delete();
    i = 0;
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0));  // fetch
    while (exp_q.size() < max_n) begin
      note = int'(song[i][7:4]);
      dur  = int'(song[i][3:0]);
      if (dur != 0) begin
        hp = int'(hp_ref[note]);
        repeat (dur * U) exp_q.push_back(mk(1, 1, hp != 0, hp, i, 0));
        repeat (G) exp_q.push_back(mk(1, 1, 0, hp, i, 0));
        if (i != LEN - 1) begin
          i++;
          exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
          continue;
        end
      end
      exp_q.push_back(mk(0, 1, 0, 0, 0, !lp));  // end of song
      if (!lp) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  // back to idle
        break;
      end
      i = 0;
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
    end
  endtask

  // noise: 0 none, 1 random writes/starts while busy, 2 write+start every busy cycle.
  task automatic run_song(input string name, input bit lp, input int max_n, input int noise);
    int n;
    build_trace(lp, max_n);
    n = (exp_q.size() < max_n) ? exp_q.size() : max_n;
    loop  = lp;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check_obs($sformatf("%s cyc%0d", name, k + 1), exp_q[k]);
      wr_en = 1'b0;
      start = 1'b0;
      if (noise == 1 && exp_q[k].busy) begin
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom);
        wr_data = 8'($urandom);
        start   = ($urandom_range(0, 7) == 0);
      end else if (noise == 2 && exp_q[k].busy) begin
        wr_en   = 1'b1;
        wr_addr = AW'($urandom);
        wr_data = 8'h8F;
        start   = 1'b1;
      end
      if (k < n - 1) step();
    end
    wr_en = 1'b0;
    start = 1'b0;
    if (exp_q[n-1].busy) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_obs({name, " stop"}, mk(0, 0, 0, 0, 0, 0));
    end
    loop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    hp_ref = '{0, 3822, 3405, 3034, 2865, 2551, 2273, 2024, 1911, 0, 0, 0, 0, 0, 0, 0};
    vecs = '{'{8'h01, 13'd0, 1'b0},    '{8'h12, 13'd3822, 1'b1},
             '{8'h23, 13'd3405, 1'b1}, '{8'h31, 13'd3034, 1'b1},
             '{8'h42, 13'd2865, 1'b1}, '{8'h53, 13'd2551, 1'b1},
             '{8'h61, 13'd2273, 1'b1}, '{8'h72, 13'd2024, 1'b1},
             '{8'h83, 13'd1911, 1'b1}, '{8'h91, 13'd0, 1'b0},
             '{8'hA2, 13'd0, 1'b0},    '{8'hB3, 13'd0, 1'b0},
             '{8'hC1, 13'd0, 1'b0},    '{8'hD2, 13'd0, 1'b0},
             '{8'hE3, 13'd0, 1'b0},    '{8'hF1, 13'd0, 1'b0}};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    step();
    check_obs("reset", mk(1, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // Note decode vectors: FETCH cycle, first PLAY cycle, then abort.
    write_entry(1, 8'h00);
    foreach (vecs[v]) begin
      write_entry(0, vecs[v].data);
      start = 1'b1;
      step();
      start = 1'b0;
      check_obs($sformatf("vec%0d fetch", v), mk(0, 1, 0, 0, 0, 0));
      step();
      check_obs($sformatf("vec%0d play", v), mk(vecs[v].tone, 1, vecs[v].tone, vecs[v].hp, 0, 0));
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_obs($sformatf("vec%0d abort", v), mk(0, 0, 0, 0, 0, 0));
    end

    // Two notes then an end marker.
    write_entry(0, 8'h12); write_entry(1, 8'h81); write_entry(2, 8'h00); write_entry(3, 8'h00);
    run_song("basic", 0, 1000, 0);

    // No end marker, looping: wraps back to entry 0 without done.
    write_entry(0, 8'h11); write_entry(1, 8'h21); write_entry(2, 8'h31); write_entry(3, 8'h41);
    run_song("loop", 1, 70, 0);

    // Explicit rest and an unused code.
    write_entry(0, 8'h03); write_entry(1, 8'hA1); write_entry(2, 8'h00);
    run_song("rest", 0, 1000, 0);

    // Stop mid-PLAY, then replay from entry 0.
    write_entry(0, 8'h52); write_entry(1, 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check_obs("midplay", mk(1, 1, 1, 2551, 0, 0));
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_obs("stop abort", mk(0, 0, 0, 0, 0, 0));
    run_song("after stop", 0, 1000, 0);

    // Writes and starts while busy are ignored.
    write_entry(0, 8'h22); write_entry(1, 8'h32); write_entry(2, 8'h00);
    run_song("busy wr", 0, 1000, 2);
    run_song("busy wr replay", 0, 1000, 0);

    // Reset during GAP (cycle 6 of entry 0x11), table survives.
    write_entry(0, 8'h11); write_entry(1, 8'h21); write_entry(2, 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check_obs("gap hold", mk(1, 1, 0, 3822, 0, 0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_obs("rst in gap", mk(1, 0, 0, 0, 0, 0));
    run_song("after rst", 0, 1000, 0);

    // start and stop together while idle.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check_obs("start+stop idle", mk(0, 0, 0, 0, 0, 0));
    step();
    check_obs("start+stop idle2", mk(0, 0, 0, 0, 0, 0));

    // Write in the same cycle as start: FETCH sees the new entry.
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 8'h71;
    song[0] = 8'h71;
    run_song("wr with start", 0, 1000, 0);

    // Randomised songs with random busy-time writes and starts.
    for (int it = 0; it < 40; it++) begin
      bit lp;
      for (int a = 0; a < int'(LEN); a++) begin
        logic [3:0] nt, du;
        nt = 4'($urandom_range(0, 15));
        du = ($urandom_range(0, 6) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
        write_entry(a, {nt, du});
      end
      lp = ($urandom_range(0, 3) == 0);
      run_song($sformatf("rand%0d", it), lp, lp ? 120 : 2000, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream note sequencer for the square-wave tone generator.
- Plays a programmable song table: each entry holds a note code and a duration.
- Drives the generator with a half-period value plus a tone enable, and inserts a silent gap between notes so that repeated notes stay audible as separate notes.
- Sits between the control/button logic (start, stop, loop, table writes) and the tone generator.

Parameters:
- SONG_LEN, default 16: number of table entries; power of two, >=2.
- UNIT_CYCLES, default 1500000: clk cycles per duration unit.
- GAP_CYCLES, default 120000: clk cycles of silence after each note; must be >=1.
- AW, default $clog2(SONG_LEN): table address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins playback at entry 0 when idle.
- stop  in  1  level/pulse; aborts playback.
- loop  in  1  sampled at end of song; 1 = restart at entry 0.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address.
- wr_data  in  8  entry {note[7:4], dur[3:0]}.
- half_period  out  13  divider terminal count for the tone generator, in its prescaled ticks.
- tone_en  out  1  1 = generator must toggle; 0 = silent.
- note_idx  out  AW  index of the entry being played.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a non-looping song ends.

Behaviour:
- Reset (synchronous, active-high): state IDLE; half_period=0, tone_en=0, note_idx=0, busy=0, done=0. Reset does not clear table contents (RAM contents are undefined after power-up).
- Table:
  - SONG_LEN x 8 register array.
  - Write occurs on clk when wr_en=1 and busy=0; writes while busy are ignored.
  - Read is registered (1-cycle).
- Entry decode:
  - note 0 = rest: tone_en=0 for the whole duration.
  - note 1..8 = duo, lai, mi, fa, suo, la, xi, duo1, with half_period 3822, 3405, 3034, 2865, 2551, 2273, 2024, 1911.
  - note 9..15 treated as rest.
  - dur 0 = end-of-song marker; dur 1..15 = units.
- States:
  - IDLE: outputs silent. start=1 -> FETCH with addr=0.
  - FETCH: 1 cycle; registered table read of addr.
  - PLAY:
    - On entry, load cnt = dur*UNIT_CYCLES-1, set half_period, tone_en and note_idx=addr.
    - Decrement cnt each cycle; leave when cnt==0 -> GAP.
    - PLAY length is exactly dur*UNIT_CYCLES cycles.
    - If the fetched dur==0, go to END instead (no tone, 0 cycles of PLAY).
  - GAP:
    - tone_en=0, half_period held, for exactly GAP_CYCLES cycles.
    - Then addr+1 -> FETCH.
    - If addr==SONG_LEN-1, go to END instead (wrap-around counts as end of song).
  - END: 1 cycle.
    - If loop=1: addr=0 -> FETCH.
    - Else: done=1 for this cycle -> IDLE.
- Latency: start sampled at cycle 0 -> FETCH at cycle 1 -> PLAY outputs valid from cycle 2.
- Counter: cnt is wide enough for 15*UNIT_CYCLES; the product is computed at parameter width with no overflow.
- Simultaneous events and aborts:
  - stop has priority over everything: in any non-IDLE state, stop=1 -> IDLE next cycle with tone_en=0, busy=0, done=0.
  - start while busy is ignored.
  - start and stop in the same cycle while IDLE: stay IDLE.
  - wr_en in the same cycle as start (busy=0): the write is applied; FETCH reads the new value.
- Mid-operation reset: identical to power-up reset; the next start plays from entry 0.
- done never asserts on a stop abort or during a looping song.

Decomposition:
- Shared package melody_pkg holds:
  - note code constants NOTE_REST, NOTE_DUO..NOTE_DUO1;
  - half-period constants 3822..1911 (shared with the tone generator);
  - state encoding IDLE/FETCH/PLAY/GAP/END;
  - entry field positions.
- One sub-module is natural: note_lut (combinational note code -> 13-bit half_period, plus a valid flag for codes 1..8).

Test Plan (UNIT_CYCLES=4, GAP_CYCLES=2, SONG_LEN=4):
- Reset, write entries {0x12,0x81,0x00,…}, start=1 at cycle 0 -> cycles 2-9 half_period=3822, tone_en=1, note_idx=0; cycles 10-11 tone_en=0; cycle 13 note 8 half_period=1911 for 4 cycles; GAP; end marker -> done=1 for exactly one cycle; then busy=0.
- Table with no end marker, loop=1 -> after entry 3's GAP, FETCH addr 0 again and note_idx returns to 0; done stays 0.
- Entry 0x03 (rest, 3 units) and 0xA1 (code 10) -> tone_en=0 for 12 cycles and 4 cycles respectively, busy=1 throughout.
- stop asserted mid-PLAY -> next cycle tone_en=0, busy=0, done=0; a following start replays from note_idx=0.
- wr_en during busy with new data -> table unchanged (replay shows the old note); start while busy -> no restart, and note_idx progresses normally.
- rst asserted in GAP -> next cycle all outputs at reset values; table contents preserved (a replay plays the same notes).
